// File: rtl/ds_bitstream_decim.sv
// Delta-sigma bitstream decimator: 1-bit pulse-density input to 8-bit PCM samples.
// Default build is a sinc1 boxcar; define DSADC_SINC2_EN for a second-order sinc^2 CIC.
module ds_bitstream_decim #(
    parameter int DECIM_LOG2 = 8  // window W = 2**DECIM_LOG2, legal 8..12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    input  logic       en,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       overrun
);

    localparam logic [DECIM_LOG2-1:0] WCNT_LAST = '1;

    logic                  sin_m;
    logic                  sin_s;
    logic [DECIM_LOG2-1:0] wcnt;
    logic                  win_end;
    logic [7:0]            res;
    logic                  res_ok;

    // Two-flop synchronizer; sin is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sin_m <= 1'b0;
            sin_s <= 1'b0;
        end else begin
            sin_m <= sin;
            sin_s <= sin_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign win_end = en && (wcnt == WCNT_LAST);

`ifdef DSADC_SINC2_EN
    localparam int IW = 2 * DECIM_LOG2 + 1;

    logic [IW-1:0] int1;
    logic [IW-1:0] int2;
    logic [IW-1:0] int1_n;
    logic [IW-1:0] int2_n;
    logic [IW-1:0] cd1;
    logic [IW-1:0] cd2;
    logic [IW-1:0] comb1;
    logic [IW-1:0] comb2;
    logic          primed;

    // Integrators wrap modulo 2**IW; the combs recover the exact difference.
    assign int1_n = int1 + IW'(sin_s);
    assign int2_n = int2 + int1_n;
    assign comb1  = int2_n - cd1;
    assign comb2  = comb1 - cd2;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            int1   <= '0;
            int2   <= '0;
            cd1    <= '0;
            cd2    <= '0;
            primed <= 1'b0;
        end else begin
            int1 <= int1_n;
            int2 <= int2_n;
            if (win_end) begin
                cd1    <= int2_n;
                cd2    <= comb1;
                primed <= 1'b1;
            end
        end
    end

    // comb2 reaches W**2 only for all ones; clamp that single code to full scale.
    assign res    = comb2[IW-1] ? 8'hFF : comb2[IW-2 -: 8];
    assign res_ok = primed;
`else
    logic [DECIM_LOG2:0]   ocnt;
    logic [DECIM_LOG2:0]   sum;
    logic [DECIM_LOG2-1:0] sum_sat;

    assign sum     = ocnt + {{DECIM_LOG2{1'b0}}, sin_s};
    assign sum_sat = sum[DECIM_LOG2] ? '1 : sum[DECIM_LOG2-1:0];
    assign res     = sum_sat[DECIM_LOG2-1 -: 8];
    assign res_ok  = 1'b1;

    // Cleared on the window-end edge itself so the next window loses no sample.
    always_ff @(posedge clk) begin
        if (!rst_n || !en || win_end) begin
            ocnt <= '0;
        end else begin
            ocnt <= sum;
        end
    end
`endif

    // Handshake: a sample transfers on any edge where dout_valid && dout_ready;
    // a new result may replace dout in that same edge, otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_end && res_ok) begin
            if (!dout_valid || dout_ready) begin
                dout       <= res;
                dout_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
